// File: rtl/seq_detect_moore_prog_if.sv
// Bundle of the serial-stream and control signals of seq_detect_moore_prog.
//   master : drives x, x_valid, pat_load, pattern_in, overlap_en, cnt_clr;
//            observes z, match_cnt, cnt_sat.
//   slave  : the detector; receives the controls and drives the three results.
interface seq_detect_moore_prog_if #(
    parameter int PAT_LEN = 5,
    parameter int CNT_W   = 8
);
    logic               x;
    logic               x_valid;
    logic               pat_load;
    logic [PAT_LEN-1:0] pattern_in;
    logic               overlap_en;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output x, x_valid, pat_load, pattern_in, overlap_en, cnt_clr,
        input  z, match_cnt, cnt_sat
    );

    modport slave (
        input  x, x_valid, pat_load, pattern_in, overlap_en, cnt_clr,
        output z, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_moore_prog.sv
// Programmable Moore serial pattern detector with longest-prefix (KMP) fallback
// and a saturating match counter.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (state 0, pattern = PAT_DEFAULT, counter 0)
//   bus  : slave side of seq_detect_moore_prog_if
//          x / x_valid        serial bit and its qualifier
//          pat_load/pattern_in load a new pattern (MSB is first bit), restarts matching
//          overlap_en          1 = matches may overlap, 0 = restart after a match
//          cnt_clr             synchronous clear of match_cnt and cnt_sat
//          z                   high while the full pattern is matched
//          match_cnt / cnt_sat saturating match count and sticky saturation flag
module seq_detect_moore_prog #(
    parameter int                 PAT_LEN     = 5,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 5'b11011,
    parameter int                 CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_detect_moore_prog_if.slave bus
);
    localparam int               ST_W    = $clog2(PAT_LEN + 1);
    localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1'b1);

    // Mask selecting the low 'len' bits of a pattern-wide vector.
    function automatic logic [PAT_LEN-1:0] low_mask(input int len);
        logic [PAT_LEN-1:0] m;
        for (int i = 0; i < PAT_LEN; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

    // The state is simply the count of pattern prefix bits matched so far.
    logic [ST_W-1:0]    state_r;
    logic [PAT_LEN-1:0] pattern_r;
    logic               z_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sat_r;

    logic               legal_s;
    logic [ST_W-1:0]    prefix_len_s;
    logic [PAT_LEN-1:0] hist_s;
    logic [PAT_LEN-1:0] cand_s;
    logic [ST_W-1:0]    fit_s;
    logic [ST_W-1:0]    state_nx_s;
    logic               hit_s;

    // Next-state: longest pattern prefix that is a suffix of (current prefix, x).
    always_comb begin
        legal_s      = (state_r <= FULL);
        prefix_len_s = {ST_W{1'b0}};
        hist_s       = {PAT_LEN{1'b0}};
        cand_s       = {PAT_LEN{1'b0}};
        fit_s        = {ST_W{1'b0}};
        state_nx_s   = state_r;
        hit_s        = 1'b0;

        // A full match either keeps the whole pattern as history (overlap)
        // or is treated as if nothing had been matched.
        if (state_r == FULL) begin
            prefix_len_s = bus.overlap_en ? FULL : {ST_W{1'b0}};
        end else if (legal_s) begin
            prefix_len_s = state_r;
        end else begin
            prefix_len_s = {ST_W{1'b0}};
        end

        // The matched prefix is the top prefix_len_s bits of the pattern;
        // right-align it and append x. Bits above prefix_len_s+1 are zero
        // and are excluded by the length guard below.
        hist_s = pattern_r >> (FULL - prefix_len_s);
        cand_s = {hist_s[PAT_LEN-2:0], bus.x};

        // Ascending sweep so the longest fitting length wins.
        for (int l = 1; l <= PAT_LEN; l++) begin
            if ((l <= int'(prefix_len_s) + 1) &&
                (((cand_s ^ (pattern_r >> (PAT_LEN - l))) & low_mask(l)) == {PAT_LEN{1'b0}})) begin
                fit_s = ST_W'(l);
            end else begin
                fit_s = fit_s;
            end
        end

        if (!legal_s) begin
            state_nx_s = {ST_W{1'b0}};
        end else if (bus.pat_load) begin
            state_nx_s = {ST_W{1'b0}};
        end else if (bus.x_valid) begin
            state_nx_s = fit_s;
        end else begin
            state_nx_s = state_r;
        end

        hit_s = legal_s && !bus.pat_load && bus.x_valid && (fit_s == FULL);
    end

    // State, pattern and match-flag registers; z tracks state == PAT_LEN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= {ST_W{1'b0}};
            pattern_r <= PAT_DEFAULT;
            z_r       <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            z_r     <= (state_nx_s == FULL);
            if (bus.pat_load) begin
                pattern_r <= bus.pattern_in;
            end else begin
                pattern_r <= pattern_r;
            end
        end
    end

    // Saturating match counter; clear beats a simultaneous match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else if (bus.cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else if (hit_s) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= cnt_r;
                sat_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
                sat_r <= sat_r | (cnt_r == CNT_PRE);
            end
        end else begin
            cnt_r <= cnt_r;
            sat_r <= sat_r;
        end
    end

    assign bus.z         = z_r;
    assign bus.match_cnt = cnt_r;
    assign bus.cnt_sat   = sat_r;
endmodule

// File: tb/tb_seq_detect_moore_prog.sv
// Self-checking bench for seq_detect_moore_prog (PAT_LEN=5, CNT_W=8).
// The driver applies one input vector per cycle and pushes the expected
// outputs, computed from a window of recently accepted bits, into a queue;
// the monitor pops and compares one entry after every rising edge.
`timescale 1ns/1ps
module tb_seq_detect_moore_prog;
    localparam int PL = 5;
    localparam int CW = 8;

    typedef struct packed {
        logic          z;
        logic [CW-1:0] cnt;
        logic          sat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model state: last accepted bits since the last restart point.
    logic [PL-1:0] m_pat;
    logic [PL-1:0] m_win;
    int            m_len;
    bit            m_z;
    int            m_cnt;
    bit            m_sat;

    seq_detect_moore_prog_if #(.PAT_LEN(PL), .CNT_W(CW)) bus ();

    seq_detect_moore_prog #(.PAT_LEN(PL), .PAT_DEFAULT(5'b11011), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge issued by the driver.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("z", int'(bus.z), int'(e.z));
            chk("match_cnt", int'(bus.match_cnt), int'(e.cnt));
            chk("cnt_sat", int'(bus.cnt_sat), int'(e.sat));
        end
    end

    function automatic void model_reset();
        m_pat = 5'b11011;
        m_win = 5'b00000;
        m_len = 0;
        m_z   = 1'b0;
        m_cnt = 0;
        m_sat = 1'b0;
    endfunction

    task automatic drive(input bit xb, input bit xv, input bit ld,
                         input logic [PL-1:0] pin, input bit ov, input bit clr);
        bit   hit;
        exp_t e;
        @(negedge clk);
        bus.x          = xb;
        bus.x_valid    = xv;
        bus.pat_load   = ld;
        bus.pattern_in = pin;
        bus.overlap_en = ov;
        bus.cnt_clr    = clr;
        hit = 1'b0;
        if (ld) begin
            m_pat = pin;
            m_win = 5'b00000;
            m_len = 0;
            m_z   = 1'b0;
        end else if (xv) begin
            if (m_z && !ov) begin
                m_win = 5'b00000;
                m_len = 0;
            end
            m_win = {m_win[PL-2:0], xb};
            if (m_len < PL) m_len++;
            m_z = (m_len == PL) && (m_win == m_pat);
            hit = m_z;
        end
        if (clr) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (hit) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_cnt == (1 << CW) - 1) m_sat = 1'b1;
        end
        e.z   = m_z;
        e.cnt = m_cnt[CW-1:0];
        e.sat = m_sat;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        bus.x_valid  = 1'b0;
        bus.pat_load = 1'b0;
        bus.cnt_clr  = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_z", int'(bus.z), 0);
        chk("async_rst_cnt", int'(bus.match_cnt), 0);
        chk("async_rst_sat", int'(bus.cnt_sat), 0);
        model_reset();
        e.z = 1'b0; e.cnt = '0; e.sat = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input bit ov, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 5'b00000, ov, 1'b0);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0, 5'b00000, ov, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PL-1:0] picks [4];
        logic [PL-1:0] pin;
        bit ov;
        picks[0] = 5'b10101; picks[1] = 5'b11111; picks[2] = 5'b11011; picks[3] = 5'b10010;
        rst = 1'b0;
        bus.x = 1'b0; bus.x_valid = 1'b0; bus.pat_load = 1'b0;
        bus.pattern_in = 5'b00000; bus.overlap_en = 1'b1; bus.cnt_clr = 1'b0;
        model_reset();
        do_reset();

        // Basic match, overlapping pair, non-overlapping pair, KMP fallback.
        feed(16'b11011, 5, 1'b1, 0);
        do_reset();
        feed(16'b11011011, 8, 1'b1, 0);
        do_reset();
        feed(16'b11011011, 8, 1'b0, 0);
        do_reset();
        feed(16'b111011, 6, 1'b1, 0);
        // Valid gating with idle cycles; z holds across gaps.
        do_reset();
        feed(16'b11011, 5, 1'b1, 3);

        // Load during a partial match; the load-cycle bit is ignored.
        feed(16'b10, 2, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b1, 5'b10101, 1'b1, 1'b0);
        feed(16'b1010101, 7, 1'b1, 0);

        // Saturation with an all-ones pattern, then clear on a match cycle.
        drive(1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0);

        // Reset mid-stream restores the default pattern and drops the partial match.
        drive(1'b0, 1'b0, 1'b1, 5'b00111, 1'b1, 1'b0);
        feed(16'b001, 3, 1'b1, 0);
        do_reset();
        feed(16'b11011, 5, 1'b1, 0);

        // Randomized traffic.
        ov = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) == 0) ov = ~ov;
            if ($urandom_range(0, 59) == 0) begin
                pin = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 3)] : PL'($urandom);
                drive(1'($urandom), 1'($urandom), 1'b1, pin, ov, 1'b0);
            end else begin
                drive(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 5'b00000, ov,
                      ($urandom_range(0, 199) == 0));
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
